// File: rtl/ext_bus_ctl.sv
// External multiplexed 16-bit AD bus controller.
// Round-robin arbitration between an instruction-fetch requester (0) and a
// data/MMIO requester (1); each grant runs a two-phase address latch sequence
// followed by a single 16-bit read or write strobe.
module ext_bus_ctl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [15:0] ad_o,
  output logic        ad_oe,
  input  logic [15:0] ad_i,
  output logic        ALE0,
  output logic        ALE1,
  output logic        OE_N,
  output logic        WE_N,
  output logic        BHE_N
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StAlo, StAloH, StAhi, StAhiH, StWr, StWrH, StTa, StRd, StRdH, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q;       // granted requester of the current transaction
  logic        last_q;      // requester granted most recently
  logic        we_q;
  logic [31:0] a_q;         // effective address, a[0] = ~be[0]
  logic [15:0] wdata_q;
  logic        bhe_n_q;
  logic [3:0]  wait_q;
  logic [15:0] rdata_q;

  logic        any_req;
  logic        gnt_sel;
  logic [1:0]  be_sel;
  logic [1:0]  be_eff;
  logic        grant;

  // Byte address bit 0 is replaced by the low-byte enable.
  logic        unused_addr_lsb;
  assign unused_addr_lsb = addr0[0] ^ addr1[0];

  // Round-robin pick: contention goes to whoever was not granted last.
  always_comb begin
    any_req = req0 | req1;
    gnt_sel = req1 & ~(req0 & last_q);
    be_sel  = gnt_sel ? be1 : be0;
    be_eff  = (be_sel == 2'b00) ? 2'b11 : be_sel;
    grant   = (state_q == StIdle) && any_req;
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (any_req) state_d = StAlo;
      StAlo:  state_d = StAloH;
      StAloH: state_d = StAhi;
      StAhi:  state_d = StAhiH;
      StAhiH: state_d = we_q ? StWr : StTa;
      StWr:   if (wait_q == 4'd0) state_d = StWrH;
      StWrH:  state_d = StDone;
      StTa:   state_d = StRd;
      StRd:   if (wait_q == 4'd0) state_d = StRdH;
      StRdH:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus pin and ack decode, purely from state so reset takes effect at once.
  always_comb begin
    ad_o  = 16'h0000;
    ad_oe = 1'b0;
    ALE0  = 1'b0;
    ALE1  = 1'b0;
    OE_N  = 1'b1;
    WE_N  = 1'b1;
    BHE_N = 1'b1;
    ack0  = 1'b0;
    ack1  = 1'b0;
    unique case (state_q)
      StAlo: begin
        ad_oe = 1'b1; ad_o = a_q[15:0]; ALE0 = 1'b1; BHE_N = bhe_n_q;
      end
      StAloH: begin
        ad_oe = 1'b1; ad_o = a_q[15:0]; BHE_N = bhe_n_q;
      end
      StAhi: begin
        ad_oe = 1'b1; ad_o = a_q[31:16]; ALE1 = 1'b1; BHE_N = bhe_n_q;
      end
      StAhiH: begin
        ad_oe = 1'b1; ad_o = a_q[31:16]; BHE_N = bhe_n_q;
      end
      StWr: begin
        ad_oe = 1'b1; ad_o = wdata_q; WE_N = 1'b0; BHE_N = bhe_n_q;
      end
      StWrH: begin
        ad_oe = 1'b1; ad_o = wdata_q; BHE_N = bhe_n_q;
      end
      StTa:   BHE_N = bhe_n_q;
      StRd: begin
        OE_N = 1'b0; BHE_N = bhe_n_q;
      end
      StRdH:  BHE_N = bhe_n_q;
      StDone: begin
        ack0 = ~gnt_q; ack1 = gnt_q;
      end
      default: ;
    endcase
  end

  // Transaction capture at grant; later requester input changes are ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      a_q     <= 32'h0;
      wdata_q <= 16'h0;
      bhe_n_q <= 1'b1;
    end else if (grant) begin
      gnt_q   <= gnt_sel;
      last_q  <= gnt_sel;
      we_q    <= gnt_sel ? we1 : we0;
      a_q     <= {(gnt_sel ? addr1[31:1] : addr0[31:1]), ~be_eff[0]};
      wdata_q <= gnt_sel ? wdata1 : wdata0;
      bhe_n_q <= ~be_eff[1];
    end
  end

  // Strobe wait counter, reloaded on entry to the strobe states.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_q <= 4'd0;
    end else if ((state_d == StWr && state_q != StWr) ||
                 (state_d == StRd && state_q != StRd)) begin
      wait_q <= WaitLoad;
    end else if ((state_q == StWr || state_q == StRd) && wait_q != 4'd0) begin
      wait_q <= wait_q - 4'd1;
    end
  end

  // Read data sampled on the last strobe cycle and held until the next read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rdata_q <= 16'h0;
    else if (state_q == StRd && wait_q == 4'd0) rdata_q <= ad_i;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_ext_bus_ctl.sv
// Directed and randomised bench for ext_bus_ctl with a simple AD-bus board model.
module tb_ext_bus_ctl;

  logic        CLK;
  logic        RST_N;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  be0, be1;
  logic        ack0, ack1;
  logic [15:0] rdata, ad_o, ad_i;
  logic        ad_oe, ALE0, ALE1, OE_N, WE_N, BHE_N;

  logic        r5_req0, r5_req1, r5_we0, r5_we1;
  logic [31:0] r5_addr0, r5_addr1;
  logic [15:0] r5_wdata0, r5_wdata1;
  logic [1:0]  r5_be0, r5_be1;
  logic        r5_ack0, r5_ack1;
  logic [15:0] r5_rdata, r5_ad_o, r5_ad_i;
  logic        r5_ad_oe, r5_ALE0, r5_ALE1, r5_OE_N, r5_WE_N, r5_BHE_N;

  int checks = 0;
  int errors = 0;
  int inv_viol = 0;

  ext_bus_ctl #(.WAIT_CYCLES(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .ad_o(ad_o), .ad_oe(ad_oe), .ad_i(ad_i),
    .ALE0(ALE0), .ALE1(ALE1), .OE_N(OE_N), .WE_N(WE_N), .BHE_N(BHE_N)
  );

  ext_bus_ctl #(.WAIT_CYCLES(5)) dut5 (
    .CLK(CLK), .RST_N(RST_N),
    .req0(r5_req0), .req1(r5_req1), .we0(r5_we0), .we1(r5_we1),
    .addr0(r5_addr0), .addr1(r5_addr1), .wdata0(r5_wdata0), .wdata1(r5_wdata1),
    .be0(r5_be0), .be1(r5_be1), .ack0(r5_ack0), .ack1(r5_ack1), .rdata(r5_rdata),
    .ad_o(r5_ad_o), .ad_oe(r5_ad_oe), .ad_i(r5_ad_i),
    .ALE0(r5_ALE0), .ALE1(r5_ALE1), .OE_N(r5_OE_N), .WE_N(r5_WE_N), .BHE_N(r5_BHE_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Board model: address latches plus word memory with byte-lane writes.
  logic [15:0] lat_lo = 16'h0, lat_hi = 16'h0;
  bit   [15:0] mem [bit [30:0]];

  function automatic bit [15:0] board_get(input bit [30:0] key);
    return mem.exists(key) ? mem[key] : 16'h0000;
  endfunction

  always @(posedge CLK) begin
    bit [15:0] w;
    bit [30:0] key;
    key = {lat_hi, lat_lo[15:1]};
    if (!WE_N) begin
      w = board_get(key);
      if (!lat_lo[0]) w[7:0]  = ad_o[7:0];
      if (!BHE_N)     w[15:8] = ad_o[15:8];
      mem[key] = w;
    end
    if (ALE0) lat_lo <= ad_o;
    if (ALE1) lat_hi <= ad_o;
  end

  always @(negedge CLK) begin
    ad_i <= OE_N ? 16'h0000 : board_get({lat_hi, lat_lo[15:1]});
  end

  // Pin-level invariants over the whole run.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (ad_oe && !OE_N) inv_viol++;
      if (ALE0 && ALE1) inv_viol++;
      if (ack0 && ack1) inv_viol++;
      if (r5_ad_oe && !r5_OE_N) inv_viol++;
      if (r5_ALE0 && r5_ALE1) inv_viol++;
    end
  end

  // Per-transaction observations; cycle 1 is the first cycle after the grant edge.
  int          m_cyc, m_ale0_cyc, m_ack_cyc, m_oe_cnt, m_we_cnt;
  logic [15:0] m_ale0_ad, m_ale1_ad, m_rdata;
  logic        m_bhe1, m_we_bad, m_ack_who, m_timeout, m_two_acks;

  task automatic run_txn(input int r, input bit we, input logic [31:0] a,
                         input logic [15:0] wd, input logic [1:0] be, input int budget);
    bit done;
    @(negedge CLK);
    if (r == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; be0 = be;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; be1 = be;
    end
    m_cyc = 0; m_ale0_cyc = 0; m_ack_cyc = 0; m_oe_cnt = 0; m_we_cnt = 0;
    m_ale0_ad = 16'hxxxx; m_ale1_ad = 16'hxxxx; m_rdata = 16'hxxxx;
    m_bhe1 = 1'bx; m_we_bad = 1'b0; m_ack_who = 1'bx; m_two_acks = 1'b0;
    done = 1'b0;
    while (!done && m_cyc < budget) begin
      @(negedge CLK);
      m_cyc++;
      if (m_cyc == 1) m_bhe1 = BHE_N;
      if (ALE0) begin m_ale0_cyc = m_cyc; m_ale0_ad = ad_o; end
      if (ALE1) m_ale1_ad = ad_o;
      if (!OE_N) m_oe_cnt++;
      if (!WE_N) begin
        m_we_cnt++;
        if (ad_o !== wd) m_we_bad = 1'b1;
      end
      if (ack0 || ack1) begin
        done = 1'b1;
        m_ack_cyc = m_cyc; m_ack_who = ack1; m_two_acks = ack0 & ack1; m_rdata = rdata;
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    m_timeout = !done;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #2;
    checks++;
    if ({ALE0, ALE1, OE_N, WE_N, BHE_N, ad_oe, ack0, ack1} !== 8'b00111000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00111000",
               {ALE0, ALE1, OE_N, WE_N, BHE_N, ad_oe, ack0, ack1});
    end
    checks++;
    if (ad_o !== 16'h0 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got ad_o=%h rdata=%h want 0000/0000", ad_o, rdata);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_read();
    mem[31'h91A2] = 16'hBEEF;
    run_txn(0, 1'b0, 32'h0001_2344, 16'h0, 2'b11, 30);
    checks++;
    if (m_ale0_cyc != 1 || m_ale0_ad !== 16'h2344) begin
      errors++;
      $display("FAIL rd_ale0 got cyc=%0d ad=%h want cyc=1 ad=2344", m_ale0_cyc, m_ale0_ad);
    end
    checks++;
    if (m_ale1_ad !== 16'h0001) begin
      errors++; $display("FAIL rd_ale1 got %h want 0001", m_ale1_ad);
    end
    checks++;
    if (m_oe_cnt != 2) begin
      errors++; $display("FAIL rd_oe_len got %0d want 2", m_oe_cnt);
    end
    checks++;
    if (m_timeout || m_ack_cyc != 9 || m_ack_who !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack got cyc=%0d who=%b to=%b want cyc=9 who=0", m_ack_cyc, m_ack_who,
               m_timeout);
    end
    checks++;
    if (m_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL rd_data got %h want BEEF", m_rdata);
    end
  endtask

  task automatic test_write();
    mem[31'h8] = 16'h1234;
    run_txn(1, 1'b1, 32'h0000_0010, 16'hA5C3, 2'b10, 30);
    checks++;
    if (m_ale0_ad !== 16'h0011) begin
      errors++; $display("FAIL wr_alo got %h want 0011", m_ale0_ad);
    end
    checks++;
    if (m_bhe1 !== 1'b0) begin
      errors++; $display("FAIL wr_bhe got %b want 0", m_bhe1);
    end
    checks++;
    if (m_we_cnt != 2 || m_we_bad) begin
      errors++;
      $display("FAIL wr_we got len=%0d bad_ad=%b want len=2 bad_ad=0", m_we_cnt, m_we_bad);
    end
    checks++;
    if (m_timeout || m_ack_cyc != 8 || m_ack_who !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack got cyc=%0d who=%b to=%b want cyc=8 who=1", m_ack_cyc, m_ack_who,
               m_timeout);
    end
    checks++;
    if (board_get(31'h8) !== 16'hA534) begin
      errors++; $display("FAIL wr_board got %h want A534", board_get(31'h8));
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int cyc;
    logic [3:0] order;
    bit dbl;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h300; wdata0 = 16'h1111; be0 = 2'b11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h302; wdata1 = 16'h2222; be1 = 2'b11;
    n = 0; cyc = 0; order = 4'b0000; dbl = 1'b0;
    while (n < 4 && cyc < 80) begin
      @(negedge CLK);
      cyc++;
      if (ack0 && ack1) dbl = 1'b1;
      if (ack0 || ack1) begin
        order[n] = ack1;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (n != 4 || order !== 4'b1010) begin
      errors++; $display("FAIL rr_order got n=%0d order=%b want n=4 order=1010", n, order);
    end
    checks++;
    if (dbl) begin
      errors++; $display("FAIL rr_dual_ack got 1 want 0");
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    mem[31'h100] = 16'h5A5A;
    @(negedge CLK);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h200; be0 = 2'b11;
    cyc = 0;
    while (cyc < 6) begin
      @(negedge CLK);
      cyc++;
    end
    checks++;
    if (OE_N !== 1'b0) begin
      errors++; $display("FAIL rst_pre_rd got OE_N=%b want 0", OE_N);
    end
    RST_N = 1'b0;
    req0 = 1'b0;
    #1;
    checks++;
    if ({OE_N, ad_oe, ALE0, ALE1, ack0, ack1} !== 6'b100000) begin
      errors++;
      $display("FAIL rst_mid_rd got %b want 100000", {OE_N, ad_oe, ALE0, ALE1, ack0, ack1});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    run_txn(0, 1'b0, 32'h200, 16'h0, 2'b11, 30);
    checks++;
    if (m_timeout || m_ack_cyc != 9 || m_ack_who !== 1'b0 || m_rdata !== 16'h5A5A) begin
      errors++;
      $display("FAIL rst_recover got cyc=%0d who=%b data=%h want cyc=9 who=0 data=5A5A",
               m_ack_cyc, m_ack_who, m_rdata);
    end
  endtask

  task automatic test_wait5();
    int cyc, wecnt, ackc;
    bit done, stray;
    @(negedge CLK);
    r5_req0 = 1'b1; r5_we0 = 1'b1; r5_addr0 = 32'h40; r5_wdata0 = 16'h1357; r5_be0 = 2'b11;
    cyc = 0; wecnt = 0; ackc = 0; done = 1'b0; stray = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (r5_ALE1) r5_req0 = 1'b0;  // requester gives up during AHI
      if (!r5_WE_N) wecnt++;
      if (r5_ack1) stray = 1'b1;
      if (r5_ack0) begin done = 1'b1; ackc = cyc; end
    end
    r5_req0 = 1'b0;
    checks++;
    if (wecnt != 5) begin
      errors++; $display("FAIL w5_we_len got %0d want 5", wecnt);
    end
    checks++;
    if (!done || ackc != 11 || stray) begin
      errors++;
      $display("FAIL w5_ack got done=%b cyc=%0d stray=%b want done=1 cyc=11 stray=0",
               done, ackc, stray);
    end
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [8];
    int r, idx;
    bit we;
    logic [1:0] be;
    logic [15:0] wd;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
    for (int t = 0; t < 200; t++) begin
      r   = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 7));
      a   = 32'h100 + 32'(idx * 2) + 32'($urandom_range(0, 1));
      be  = we ? 2'($urandom_range(0, 3)) : 2'b11;
      wd  = 16'($urandom);
      run_txn(r, we, a, wd, be, 30);
      checks++;
      if (m_timeout || m_ack_who !== 1'(r) || m_two_acks) begin
        errors++;
        $display("FAIL rnd_ack t=%0d got who=%b to=%b want who=%0d", t, m_ack_who, m_timeout, r);
      end
      if (we) begin
        if (be == 2'b00) be = 2'b11;
        if (be[0]) ref_mem[idx][7:0]  = wd[7:0];
        if (be[1]) ref_mem[idx][15:8] = wd[15:8];
      end else begin
        checks++;
        if (m_rdata !== ref_mem[idx]) begin
          errors++;
          $display("FAIL rnd_read t=%0d idx=%0d got %h want %h", t, idx, m_rdata, ref_mem[idx]);
        end
      end
    end
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 16'h0; wdata1 = 16'h0; be0 = 2'b00; be1 = 2'b00;
    r5_req0 = 1'b0; r5_req1 = 1'b0; r5_we0 = 1'b0; r5_we1 = 1'b0;
    r5_addr0 = 32'h0; r5_addr1 = 32'h0; r5_wdata0 = 16'h0; r5_wdata1 = 16'h0;
    r5_be0 = 2'b00; r5_be1 = 2'b00; r5_ad_i = 16'h0;
    ad_i = 16'h0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_read();
    test_wait5();
    test_random();
    checks++;
    if (inv_viol != 0) begin
      errors++; $display("FAIL invariants got %0d violations want 0", inv_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
